// File: rtl/ohm_bcd_fmt_if.sv
// Sample/result bundle between the igniter resistance path and the BCD
// display formatter.
interface ohm_bcd_fmt_if;
  logic        valid_in;
  logic [11:0] r_in;
  logic        busy;
  logic        valid_out;
  logic [3:0]  dig_t;
  logic [3:0]  dig_o;
  logic [3:0]  dig_d;
  logic [3:0]  dig_h;
  logic        open_flag;
  logic        short_flag;
  logic        overrun;

  modport master (
    output valid_in, r_in,
    input  busy, valid_out, dig_t, dig_o, dig_d, dig_h,
           open_flag, short_flag, overrun
  );

  modport slave (
    input  valid_in, r_in,
    output busy, valid_out, dig_t, dig_o, dig_d, dig_h,
           open_flag, short_flag, overrun
  );
endinterface

// File: rtl/ohm_bcd_fmt.sv
// Converts 12-bit ADC-format resistance samples (1/32 ohm, inverted magnitude)
// into "TT.HH" BCD display digits using an iterative scale + double-dabble.
module ohm_bcd_fmt #(
  parameter logic [10:0] OPEN_CODE  = 11'h7DC,
  parameter bit          BLANK_LEAD = 1'b1
) (
  input logic         clk,
  input logic         reset,
  ohm_bcd_fmt_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCALE, CONV, OUT} state_t;

  state_t      state;
  logic [10:0] cur_mag;
  logic [10:0] pend_mag;
  logic        pend_full;
  logic [15:0] s_reg;
  logic [15:0] bcd;
  logic [3:0]  bit_cnt;

  logic [10:0] mag_in;
  logic [15:0] prod;
  logic [11:0] low_adj;

  assign mag_in = bus.r_in[11] ? 11'd0 : (bus.r_in[10:0] ^ 11'h7FF);
  assign prod   = {5'd0, cur_mag} * 16'd25 + 16'd4;
  assign bus.busy = (state != IDLE);

  // The result never exceeds 6397, so the thousands nibble is at most 4 before
  // any shift and never needs the add-3 correction; only the low three are fixed up.
  always_comb begin
    low_adj = bcd[11:0];
    for (int n = 0; n < 3; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5)
        low_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cur_mag        <= '0;
      pend_mag       <= '0;
      pend_full      <= 1'b0;
      s_reg          <= '0;
      bcd            <= '0;
      bit_cnt        <= '0;
      bus.valid_out  <= 1'b0;
      bus.dig_t      <= 4'hF;
      bus.dig_o      <= 4'h0;
      bus.dig_d      <= 4'h0;
      bus.dig_h      <= 4'h0;
      bus.open_flag  <= 1'b0;
      bus.short_flag <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid_in) begin
            cur_mag <= mag_in;
            state   <= SCALE;
          end
        end

        SCALE: begin
          // prod[15:3] is the rounded value in hundredths; it is shifted out MSB first.
          s_reg   <= prod;
          bcd     <= '0;
          bit_cnt <= 4'd12;
          state   <= CONV;
        end

        CONV: begin
          bcd     <= {bcd[14:12], low_adj, s_reg[15]};
          s_reg   <= {s_reg[14:0], 1'b0};
          bit_cnt <= bit_cnt - 4'd1;
          if (bit_cnt == 4'd0)
            state <= OUT;
        end

        OUT: begin
          bus.valid_out <= 1'b1;
          if (cur_mag == OPEN_CODE) begin
            bus.dig_t      <= 4'h3;
            bus.dig_o      <= 4'hE;
            bus.dig_d      <= 4'hE;
            bus.dig_h      <= 4'hF;
            bus.open_flag  <= 1'b1;
            bus.short_flag <= 1'b0;
          end else begin
            bus.dig_t      <= (BLANK_LEAD && bcd[15:12] == 4'h0) ? 4'hF : bcd[15:12];
            bus.dig_o      <= bcd[11:8];
            bus.dig_d      <= bcd[7:4];
            bus.dig_h      <= bcd[3:0];
            bus.open_flag  <= 1'b0;
            bus.short_flag <= (cur_mag < 11'h020);
          end

          // A fresh sample in this cycle wins over whatever is pending.
          if (bus.valid_in) begin
            cur_mag <= mag_in;
            state   <= SCALE;
            if (pend_full) begin
              bus.overrun <= 1'b1;
              pend_full   <= 1'b0;
            end
          end else if (pend_full) begin
            cur_mag   <= pend_mag;
            pend_full <= 1'b0;
            state     <= SCALE;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      if ((state == SCALE || state == CONV) && bus.valid_in) begin
        pend_mag  <= mag_in;
        pend_full <= 1'b1;
        if (pend_full)
          bus.overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ohm_bcd_fmt.sv
// Directed + randomized bench for ohm_bcd_fmt, checked against an arithmetic
// reference model (both BLANK_LEAD settings run side by side).
module tb_ohm_bcd_fmt;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   edge_cnt = 0;
  int   passed = 0;
  int   failed = 0;
  int   total = 0;

  ohm_bcd_fmt_if bus0 ();
  ohm_bcd_fmt_if bus1 ();

  ohm_bcd_fmt #(.OPEN_CODE(11'h7DC), .BLANK_LEAD(1'b1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  ohm_bcd_fmt #(.OPEN_CODE(11'h7DC), .BLANK_LEAD(1'b0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference: returns {tens, ones, tenths, hundredths, open, short}.
  function automatic logic [17:0] model(input logic [11:0] r, input bit blank);
    int mag;
    int hund;
    int t, o, d, h;
    mag = r[11] ? 0 : (2047 - int'(r[10:0]));
    if (mag == 2012) return {4'h3, 4'hE, 4'hE, 4'hF, 1'b1, 1'b0};
    hund = (mag * 25 + 4) / 8;
    t = hund / 1000;
    o = (hund / 100) % 10;
    d = (hund / 10) % 10;
    h = hund % 10;
    if (blank && t == 0) t = 15;
    return {4'(t), 4'(o), 4'(d), 4'(h), 1'b0, (mag < 32)};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [11:0] r);
    bus0.valid_in = v;
    bus0.r_in     = r;
    bus1.valid_in = v;
    bus1.r_in     = r;
  endtask

  // Called at a negedge; returns at the following negedge with valid_in low.
  task automatic apply_stimulus(input logic [11:0] r);
    drive(1'b1, r);
    @(negedge clk);
    drive(1'b0, r);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_dig0"}, {bus0.dig_t, bus0.dig_o, bus0.dig_d, bus0.dig_h}, 16'hF000);
    check_output({tag, "_dig1"}, {bus1.dig_t, bus1.dig_o, bus1.dig_d, bus1.dig_h}, 16'hF000);
    check_output({tag, "_flags"}, {bus0.valid_out, bus0.open_flag, bus0.short_flag, bus0.overrun}, 4'b0000);
    check_output({tag, "_busy"}, bus0.busy, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [11:0] r, input int t0,
                               input int lat, input logic exp_ovr);
    logic [17:0] e1;
    logic [17:0] e0;
    int waited;
    e1 = model(r, 1'b1);
    e0 = model(r, 1'b0);
    waited = 0;
    while (!bus0.valid_out && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    check_output({tag, "_seen"}, bus0.valid_out, 1'b1);
    check_output({tag, "_lat"}, edge_cnt - t0, lat);
    check_output({tag, "_dig"}, {bus0.dig_t, bus0.dig_o, bus0.dig_d, bus0.dig_h}, e1[17:2]);
    check_output({tag, "_flags"}, {bus0.open_flag, bus0.short_flag}, e1[1:0]);
    check_output({tag, "_dig_noblank"}, {bus1.dig_t, bus1.dig_o, bus1.dig_d, bus1.dig_h}, e0[17:2]);
    check_output({tag, "_ovr"}, bus0.overrun, exp_ovr);
    @(negedge clk);
    check_output({tag, "_pulse"}, bus0.valid_out, 1'b0);
  endtask

  logic [11:0] directed [6] = '{12'h75F, 12'h000, 12'h7FE, 12'h023, 12'h800, 12'h7FF};

  initial begin
    int t0;
    int seen;
    logic [11:0] ra, rb, rc;
    drive(1'b0, 12'h000);
    tick(3);
    reset = 1'b0;
    check_reset_state("reset");

    for (int i = 0; i < 6; i++) begin
      t0 = edge_cnt;
      apply_stimulus(directed[i]);
      check_output($sformatf("dir%0d_busy", i), bus0.busy, 1'b1);
      expect_result($sformatf("dir%0d", i), directed[i], t0, 16, 1'b0);
      check_output($sformatf("dir%0d_idle", i), bus0.busy, 1'b0);
      tick(1);
    end

    for (int i = 0; i < 10; i++) begin
      ra = 12'($urandom_range(0, 4095));
      t0 = edge_cnt;
      apply_stimulus(ra);
      expect_result($sformatf("rnd%0d", i), ra, t0, 16, 1'b0);
      tick(int'($urandom_range(0, 3)));
    end

    // Sample presented during OUT is taken directly, no overrun.
    ra = 12'($urandom_range(0, 2047));
    rb = 12'($urandom_range(0, 2047));
    t0 = edge_cnt;
    apply_stimulus(ra);
    tick(14);
    apply_stimulus(rb);
    expect_result("out_a", ra, t0, 16, 1'b0);
    expect_result("out_b", rb, t0, 31, 1'b0);

    // A, B, C at cycles 0, 3, 6: B is overwritten by C.
    ra = 12'($urandom_range(0, 2047));
    rb = 12'($urandom_range(0, 2047));
    rc = 12'($urandom_range(0, 2047));
    t0 = edge_cnt;
    apply_stimulus(ra);
    tick(2);
    apply_stimulus(rb);
    tick(2);
    apply_stimulus(rc);
    expect_result("ovr_a", ra, t0, 16, 1'b1);
    expect_result("ovr_c", rc, t0, 31, 1'b1);
    do_reset();
    check_reset_state("ovr_clear");

    // Pending full when a new sample arrives in OUT: pending one is discarded.
    t0 = edge_cnt;
    apply_stimulus(ra);
    tick(4);
    apply_stimulus(rb);
    tick(9);
    apply_stimulus(rc);
    expect_result("outp_a", ra, t0, 16, 1'b1);
    expect_result("outp_c", rc, t0, 31, 1'b1);
    do_reset();

    // Reset mid-conversion aborts with no result.
    apply_stimulus(12'h000);
    tick(6);
    do_reset();
    check_reset_state("midreset");
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus0.valid_out) seen++;
    end
    check_output("midreset_novalid", seen, 0);
    check_reset_state("midreset_hold");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
